alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning cycles waited after an alu_enable toggle before result capture (legal 1..15).
REQ-002 Ports: one clock, clk; reset rst, synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream issue handshake; transfer on clk edge with both high.
REQ-006 in_op / in_a / in_b / in_rd  in  5 / 16 / 16 / 4  opcode, signed operands, destination register index.
REQ-007 alu_enable  out  1  ALU trigger; the ALU evaluates on each edge, so every toggle is one operation.
REQ-008 alu_operation / alu_data_in1 / alu_data_in2  out  5 / 16 / 16  registered opcode and operands to the ALU.
REQ-009 alu_data_out / alu_flags  in  16 / 4  ALU result and flags {Z,N,C,V}.
REQ-010 out_valid / out_ready  out / in  1 / 1  writeback handshake.
REQ-011 out_data / out_flags / out_rd / out_wr_en  out  16 / 4 / 4 / 1  captured result, flags, destination, register-write qualifier.
REQ-012 flags_q  out  4  architectural flags register; busy  out  1  high in any state but IDLE.

Function
REQ-013 FSM states IDLE, ISSUE, SETTLE, HOLD; in_ready=1 only in IDLE.
REQ-014 IDLE: on accept (edge k), register op/operands/rd onto alu_* ports and enter ISSUE.
REQ-015 ISSUE: at edge k+1 toggle alu_enable, load settle counter with SETTLE_CYCLES, enter SETTLE.
REQ-016 SETTLE: decrement counter each edge; on the edge it reaches 0 (edge k+1+SETTLE_CYCLES), capture alu_data_out into out_data and alu_flags into out_flags and flags_q, set out_valid, enter HOLD.
REQ-017 Accept-to-out_valid latency is exactly SETTLE_CYCLES+2 cycles.
REQ-018 HOLD: out_* held stable while out_valid && !out_ready; on out_ready clear out_valid and return to IDLE; no new accept in the same cycle (one op in flight).
REQ-019 alu_* inputs stay constant from the ISSUE entry until HOLD exit.
REQ-020 out_wr_en=0 for cmp (10010) and unassigned opcodes 11000-11111; 1 for all others.
REQ-021 Pass opcodes (10000, 10001): flags_q is captured from alu_flags, which the ALU leaves unchanged.
REQ-022 Unassigned opcodes still run the full sequence; out_data is whatever alu_data_out holds.
REQ-023 in_valid while busy is ignored (not accepted).

Reset
REQ-024 rst wins over every other event, including a same-cycle accept or out_ready.
REQ-025 Reset values: state IDLE, alu_enable=0, alu_operation=0, alu_data_in1/2=0, out_valid=0, out_data=0, out_flags=0, out_rd=0, out_wr_en=0, flags_q=0, counter=0, err_div0=0.
REQ-026 Reset mid-operation abandons the op with no out_valid; ALU contents after reset are don't-care.

Configuration
REQ-027 Macro ALU_SEQ_DIV0_TRAP_EN.
REQ-028 Defined: adds output err_div0 (1 bit); div (01000) or mod (01001) with in_b==0 skips ISSUE/SETTLE (no alu_enable toggle), enters HOLD on edge k+1 with out_wr_en=0, out_flags=flags_q (unchanged), err_div0=1 while in HOLD.
REQ-029 Undefined: no err_div0 port; divide-by-zero follows the normal sequence and captures whatever the ALU leaves.

Structure
REQ-030 Package alu_pkg holds the 5-bit opcode localparams, flag bit indices (Z=3,N=2,C=1,V=0) and the FSM state enum.
REQ-031 One sub-module alu_op_decode: combinational opcode -> {wr_en, is_div_mod}.

Verification
REQ-032 add 0x7FFF,0x0001, rd=3, SETTLE_CYCLES=2 -> out_valid 4 cycles after accept, out_data=0x8000, out_flags=0101, out_wr_en=1, out_rd=3.
REQ-033 cmp 5,5 -> out_flags=1000, flags_q=1000, out_wr_en=0.
REQ-034 sub 3,5 then out_ready held low 5 cycles -> out_data=0xFFFE, flags N=1 stable, in_ready=0 throughout, exactly one alu_enable toggle.
REQ-035 rst asserted in SETTLE -> next cycle IDLE, out_valid=0, alu_enable=0, flags_q=0, no writeback.
REQ-036 With ALU_SEQ_DIV0_TRAP_EN: div 7,0 -> no alu_enable toggle, out_valid at accept+1, err_div0=1, out_wr_en=0, out_flags=previous flags_q.
REQ-037 Back-to-back: accept held ops while in_valid stays high -> second accepted only in the cycle after HOLD exits.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and sequencer state type for alu_sequencer.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SHL   = 5'b00101;
    localparam logic [4:0] OP_SHR   = 5'b00110;
    localparam logic [4:0] OP_MUL   = 5'b00111;
    localparam logic [4:0] OP_DIV   = 5'b01000;
    localparam logic [4:0] OP_MOD   = 5'b01001;
    localparam logic [4:0] OP_PASSA = 5'b10000;
    localparam logic [4:0] OP_PASSB = 5'b10001;
    localparam logic [4:0] OP_CMP   = 5'b10010;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classification: register-write qualifier and divide/modulo detect.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [4:0] op,
    output logic       wr_en,
    output logic       is_div_mod
);

    always_comb begin
        wr_en      = 1'b1;
        is_div_mod = 1'b0;
        // compare and the unassigned 11xxx block never write the register file
        if (op == OP_CMP || op[4:3] == 2'b11) begin
            wr_en = 1'b0;
        end
        if (op == OP_DIV || op == OP_MOD) begin
            is_div_mod = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one op at a time to an edge-triggered ALU, waits SETTLE_CYCLES, captures the result.
// Optional divide-by-zero trap (adds err_div0) enabled by defining ALU_SEQ_DIV0_TRAP_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [3:0]  in_rd,
    output logic        alu_enable,
    output logic [4:0]  alu_operation,
    output logic [15:0] alu_data_in1,
    output logic [15:0] alu_data_in2,
    input  logic [15:0] alu_data_out,
    input  logic [3:0]  alu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_flags,
    output logic [3:0]  out_rd,
    output logic        out_wr_en,
    output logic [3:0]  flags_q,
    output logic        busy
`ifdef ALU_SEQ_DIV0_TRAP_EN
    ,
    output logic        err_div0
`endif
);

`ifdef ALU_SEQ_DIV0_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [3:0]  rd_q;
    logic        dec_wr_en, dec_div_mod;
    logic        accept, toggle, capture, trap, done;

    alu_op_decode u_decode (
        .op         (alu_operation),
        .wr_en      (dec_wr_en),
        .is_div_mod (dec_div_mod)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        toggle  = 1'b0;
        capture = 1'b0;
        trap    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // operands are already registered, so the zero-divisor test uses the alu_* copies
                if (TRAP_EN && dec_div_mod && alu_data_in2 == '0) begin
                    trap    = 1'b1;
                    state_d = HOLD;
                end else begin
                    toggle  = 1'b1;
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_enable    <= 1'b0;
            alu_operation <= '0;
            alu_data_in1  <= '0;
            alu_data_in2  <= '0;
            rd_q          <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_flags     <= '0;
            out_rd        <= '0;
            out_wr_en     <= 1'b0;
            flags_q       <= '0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
            err_div0      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                alu_operation <= in_op;
                alu_data_in1  <= in_a;
                alu_data_in2  <= in_b;
                rd_q          <= in_rd;
            end
            if (toggle) begin
                alu_enable <= ~alu_enable;
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= alu_data_out;
                out_flags <= alu_flags;
                flags_q   <= alu_flags;
                out_rd    <= rd_q;
                out_wr_en <= dec_wr_en;
            end
            if (trap) begin
                out_valid <= 1'b1;
                out_flags <= flags_q;
                out_rd    <= rd_q;
                out_wr_en <= 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
                err_div0  <= 1'b1;
`endif
            end
            if (done) begin
                out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV0_TRAP_EN
                err_div0  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with an edge-triggered ALU stub and a transaction-level model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_rd;
    logic        alu_enable;
    logic [4:0]  alu_operation;
    logic [15:0] alu_data_in1, alu_data_in2;
    logic [15:0] alu_data_out = '0;
    logic [3:0]  alu_flags = '0;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags, out_rd, flags_q;
    logic        out_wr_en, busy;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    logic        err_div0;
`endif

    alu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .alu_enable(alu_enable), .alu_operation(alu_operation),
        .alu_data_in1(alu_data_in1), .alu_data_in2(alu_data_in2),
        .alu_data_out(alu_data_out), .alu_flags(alu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .flags_q(flags_q), .busy(busy)
`ifdef ALU_SEQ_DIV0_TRAP_EN
        , .err_div0(err_div0)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          model_on = 1'b0;
    int unsigned cyc = 0;
    int unsigned toggles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference ALU behaviour: flags {Z,N,C,V}; pass ops keep flags, unassigned ops keep everything.
    function automatic void alu_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] rin, input logic [3:0] fin,
                                    output logic [15:0] r, output logic [3:0] f);
        logic [16:0] wide;
        logic c, v;
        c = 1'b0; v = 1'b0; r = rin; f = fin;
        case (op)
            OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16];
                          v = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB, OP_CMP: begin r = a - b; c = (a < b);
                          v = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << b[3:0];
            OP_SHR: r = a >> b[3:0];
            OP_MUL: r = 16'(a * b);
            OP_DIV: r = (b == 0) ? 16'hFFFF : 16'($signed(a) / $signed(b));
            OP_MOD: r = (b == 0) ? a : 16'($signed(a) % $signed(b));
            OP_PASSA: begin r = a; f = fin; return; end
            OP_PASSB: begin r = b; f = fin; return; end
            default: begin r = rin; f = fin; return; end
        endcase
        f = {r == 16'h0, r[15], c, v};
    endfunction

    // ALU stub: evaluates on every alu_enable edge
    always @(posedge alu_enable or negedge alu_enable) begin
        logic [15:0] r;
        logic [3:0]  f;
        if (model_on && !rst) begin
            alu_ref(alu_operation, alu_data_in1, alu_data_in2, alu_data_out, alu_flags, r, f);
            alu_data_out <= r;
            alu_flags    <= f;
        end
    end

    // Transaction model: one op in flight, result due SETTLE+2 cycles after the handshake cycle
    bit          inflight = 1'b0, m_trap = 1'b0;
    int unsigned due = 0, acc_cyc = 0;
    logic [4:0]  m_op;
    logic [15:0] m_a, m_b, exp_data;
    logic [15:0] m_last_data = '0, m_alu_data = '0;
    logic [3:0]  m_rd, exp_flags, m_flags = '0, m_alu_flags = '0;
    logic        exp_wr;
    logic        prev_en = 1'b0;

    always @(negedge clk) begin
        bit mv;
        if (model_on) begin
            cyc++;
            if (alu_enable !== prev_en) toggles++;
            prev_en = alu_enable;
            mv = inflight && (cyc >= due);
            check("in_ready", in_ready, !inflight);
            check("busy", busy, inflight);
            check("out_valid", out_valid, mv);
            if (mv) begin
                check("out_data", out_data, exp_data);
                check("out_flags", out_flags, exp_flags);
                check("out_rd", out_rd, m_rd);
                check("out_wr_en", out_wr_en, exp_wr);
                check("flags_q", flags_q, exp_flags);
`ifdef ALU_SEQ_DIV0_TRAP_EN
                check("err_div0", err_div0, m_trap);
`endif
            end else begin
                check("flags_q_idle", flags_q, m_flags);
            end
            if (inflight && cyc > acc_cyc) begin
                check("alu_operation", alu_operation, m_op);
                check("alu_data_in1", alu_data_in1, m_a);
                check("alu_data_in2", alu_data_in2, m_b);
            end
            if (rst) begin
                inflight    = 1'b0;
                m_flags     = '0;
                m_last_data = '0;
            end else if (mv && out_ready) begin
                inflight    = 1'b0;
                m_flags     = exp_flags;
                m_last_data = exp_data;
            end else if (!inflight && in_valid) begin
                inflight = 1'b1;
                acc_cyc  = cyc;
                m_op = in_op; m_a = in_a; m_b = in_b; m_rd = in_rd;
`ifdef ALU_SEQ_DIV0_TRAP_EN
                m_trap = (in_op == OP_DIV || in_op == OP_MOD) && in_b == 16'h0;
`endif
                if (m_trap) begin
                    due       = cyc + 2;
                    exp_data  = m_last_data;
                    exp_flags = m_flags;
                    exp_wr    = 1'b0;
                end else begin
                    due = cyc + S + 2;
                    alu_ref(in_op, in_a, in_b, m_alu_data, m_alu_flags, exp_data, exp_flags);
                    m_alu_data  = exp_data;
                    m_alu_flags = exp_flags;
                    exp_wr      = !(in_op == OP_CMP || in_op[4:3] == 2'b11);
                end
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] rd, output int unsigned hs);
        bit ok = 1'b0;
        hs = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #1;
            if (in_ready) begin ok = 1'b1; hs = cyc; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned vc);
        bit ok = 1'b0;
        vc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (out_valid) begin ok = 1'b1; vc = cyc; end
            else begin @(negedge clk); #1; end
        end
        if (!ok) check("valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a, b, d;
        logic [3:0]  f;
        logic        wr;
    } vec_t;

    vec_t tbl[13] = '{
        '{OP_AND,   16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b1},
        '{OP_OR,    16'hF000, 16'h000F, 16'hF00F, 4'b0100, 1'b1},
        '{OP_XOR,   16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b1},
        '{OP_PASSA, 16'h1234, 16'h0000, 16'h1234, 4'b1000, 1'b1},
        '{OP_SHL,   16'h0001, 16'h0004, 16'h0010, 4'b0000, 1'b1},
        '{OP_SHR,   16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b1},
        '{OP_MUL,   16'h0003, 16'h0007, 16'h0015, 4'b0000, 1'b1},
        '{OP_DIV,   16'h0007, 16'h0002, 16'h0003, 4'b0000, 1'b1},
        '{OP_MOD,   16'h0007, 16'h0003, 16'h0001, 4'b0000, 1'b1},
        '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b1},
        '{OP_PASSB, 16'h5555, 16'hABCD, 16'hABCD, 4'b1010, 1'b1},
        '{5'b11010, 16'h1111, 16'h2222, 16'hABCD, 4'b1010, 1'b0},
        '{5'b11111, 16'h3333, 16'h4444, 16'hABCD, 4'b1010, 1'b0}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs, vc, hs2, t0;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_on = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu_enable", alu_enable, 1'b0);
        check("rst_alu_operation", alu_operation, 5'h0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_out_wr_en", out_wr_en, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(OP_ADD, 16'h7FFF, 16'h0001, 4'd3, hs);
        wait_valid(vc);
        check("add_latency", vc - hs, 32'd4);
        check("add_data", out_data, 16'h8000);
        check("add_flags", out_flags, 4'b0101);
        check("add_wr_en", out_wr_en, 1'b1);
        check("add_rd", out_rd, 4'd3);

        send(OP_CMP, 16'd5, 16'd5, 4'd1, hs);
        wait_valid(vc);
        check("cmp_flags", out_flags, 4'b1000);
        check("cmp_flags_q", flags_q, 4'b1000);
        check("cmp_wr_en", out_wr_en, 1'b0);

        // reset while settling: alu_enable is high at this point
        send(OP_ADD, 16'd1, 16'd2, 4'd4, hs);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("rstmid_in_ready", in_ready, 1'b1);
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_alu_enable", alu_enable, 1'b0);
        check("rstmid_flags_q", flags_q, 4'b0000);
        repeat (6) @(negedge clk);

        @(posedge clk); #1;
        out_ready = 1'b0;
        t0 = toggles;
        send(OP_SUB, 16'd3, 16'd5, 4'd2, hs);
        wait_valid(vc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("sub_hold_valid", out_valid, 1'b1);
            check("sub_hold_data", out_data, 16'hFFFE);
            check("sub_hold_N", out_flags[FLAG_N], 1'b1);
            check("sub_hold_in_ready", in_ready, 1'b0);
        end
        check("sub_toggles", toggles - t0, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i), hs);
            wait_valid(vc);
            check("tbl_data", out_data, tbl[i].d);
            check("tbl_flags", out_flags, tbl[i].f);
            check("tbl_wr_en", out_wr_en, tbl[i].wr);
        end

        t0 = toggles;
        send(OP_DIV, 16'd7, 16'd0, 4'd5, hs);
        wait_valid(vc);
`ifdef ALU_SEQ_DIV0_TRAP_EN
        check("div0_latency", vc - hs, 32'd2);
        check("div0_err", err_div0, 1'b1);
        check("div0_wr_en", out_wr_en, 1'b0);
        check("div0_flags", out_flags, 4'b1010);
        check("div0_data", out_data, 16'hABCD);
        check("div0_toggles", toggles - t0, 32'd0);
`else
        check("div0_latency", vc - hs, 32'd4);
        check("div0_data", out_data, 16'hFFFF);
        check("div0_flags", out_flags, 4'b0100);
        check("div0_wr_en", out_wr_en, 1'b1);
        check("div0_toggles", toggles - t0, 32'd1);
`endif
        repeat (2) @(negedge clk);

        // back-to-back: in_valid never drops between the two ops
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = OP_ADD; in_a = 16'd1; in_b = 16'd1; in_rd = 4'd1;
        hs = 0; hs2 = 0;
        for (int i = 0; i < 50 && hs == 0; i++) begin
            @(negedge clk); #1;
            if (in_ready) hs = cyc;
        end
        @(posedge clk); #1;
        in_a = 16'd2; in_b = 16'd2; in_rd = 4'd2;
        for (int i = 0; i < 50 && hs2 == 0; i++) begin
            @(negedge clk); #1;
            if (in_ready) hs2 = cyc;
        end
        check("b2b_gap", hs2 - hs, 32'(S + 3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(vc);
        check("b2b_data", out_data, 16'd4);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
